// File: rtl/irq_encoder_if.sv
// Request/grant bundle for irq_encoder: request lines, masks, the output
// handshake and the pending-state observation signals.
interface irq_encoder_if #(
  parameter int N = 8
);
  localparam int W = ($clog2(N) > 1) ? $clog2(N) : 1;

  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;
  logic         any_pending;

  modport master (
    output req, mask, out_ready,
    input  out_valid, out_idx, pending, any_pending
  );

  modport slave (
    input  req, mask, out_ready,
    output out_valid, out_idx, pending, any_pending
  );
endinterface

// File: rtl/irq_encoder.sv
// Interrupt request encoder: latches level requests into a pending vector and
// issues one line index at a time through a valid/ready output stage.
module irq_encoder #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input logic           clk,
  input logic           rst,
  irq_encoder_if.slave  bus
);
  localparam int W = ($clog2(N) > 1) ? $clog2(N) : 1;

  typedef enum logic {S_EMPTY, S_FULL} stage_e;

  stage_e       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q;
  logic [N-1:0] pend_q;
  logic [N-1:0] clr;
  logic [N-1:0] eligible;
  logic [N-1:0] rot;
  logic [W-1:0] winner;
  logic         found;
  logic         ack;
  int unsigned  off;
  int unsigned  sum;

  always_comb begin
    ack      = (state_q == S_FULL) && bus.out_ready;
    clr      = ack ? (N'(1) << idx_q) : '0;
    eligible = pend_q & bus.mask & ~clr;
  end

  // Round-robin search rotates a doubled copy so the first set bit of rot is
  // the first eligible line at or after ptr+1; the offset is then unrotated.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    off    = 0;
    sum    = 0;
    rot    = '0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (eligible[i]) begin
          found  = 1'b1;
          winner = W'(i);
        end
      end
    end else begin
      rot = N'({eligible, eligible} >> (32'(ptr_q) + 32'd1));
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && rot[i]) begin
          found = 1'b1;
          off   = i;
        end
      end
      sum = 32'(ptr_q) + 32'd1 + off;
      if (sum >= N) sum = sum - N;
      winner = W'(sum);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == S_EMPTY || ack) begin
      if (found) begin
        state_d = S_FULL;
        idx_d   = winner;
      end else begin
        state_d = S_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      idx_q   <= '0;
      pend_q  <= '0;
      ptr_q   <= W'(N - 1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= (pend_q & ~clr) | bus.req;
      if (ack) ptr_q <= idx_q;
    end
  end

  assign bus.out_valid   = (state_q == S_FULL);
  assign bus.out_idx     = idx_q;
  assign bus.pending     = pend_q;
  assign bus.any_pending = |pend_q;
endmodule

// File: doc/irq_encoder.md
IRQ_ENCODER -- requirements
Module: irq_encoder

Interface
REQ-001 The block SHALL have parameter N, default 8, number of request lines (legal N >= 2; N need not be a power of two).
REQ-002 The block SHALL have parameter MODE, default 0, selection policy (0 = fixed priority, highest index wins; 1 = round-robin).
REQ-003 The block SHALL have derived localparam W = max(1, ceil(log2(N))), width of the encoded index.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  N  level request lines, sampled every cycle.
REQ-007 mask  input  N  per-line enable; 1 = eligible for selection.
REQ-008 out_ready  input  1  consumer accepts out_idx this cycle.
REQ-009 out_valid  output  1  out_idx holds a selected request.
REQ-010 out_idx  output  W  encoded index of the selected line.
REQ-011 pending  output  N  registered pending-request vector.
REQ-012 any_pending  output  1  OR-reduction of pending (combinational from the register).

Function
REQ-013 ack SHALL be out_valid & out_ready; clr SHALL be onehot(out_idx) when ack, else 0.
REQ-014 Each cycle, pending SHALL update to (pending & ~clr) | req; on a same-line set and clear in one cycle, set SHALL win.
REQ-015 The eligible vector SHALL be pending & mask & ~clr, using the registered pending (req of the current cycle excluded).
REQ-016 The output stage SHALL load when out_valid = 0 or ack = 1: if eligible is nonzero, out_valid <= 1 and out_idx <= winner; otherwise out_valid <= 0.
REQ-017 While out_valid = 1 and out_ready = 0, out_valid and out_idx SHALL hold stable regardless of req, mask or pending changes.
REQ-018 A line held in the output stage SHALL remain set in pending until acked, and SHALL never be issued twice for one pending assertion.
REQ-019 MODE 0: the winner SHALL be the highest set index of eligible.
REQ-020 MODE 1: the winner SHALL be the first set bit of eligible searching upward from (ptr + 1) mod N with wrap at N-1 -> 0.
REQ-021 MODE 1: ptr (W bits) SHALL update to out_idx on ack and hold otherwise; MODE 0 SHALL ignore ptr.
REQ-022 Latency: req asserted in cycle t with output stage free and line unmasked SHALL give out_valid = 1 in cycle t+2.
REQ-023 Back-to-back: with out_ready held 1 and eligible nonzero, a new index SHALL be presented every cycle with no bubble.
REQ-024 Masking a pending line SHALL NOT clear it; it becomes selectable the cycle after mask re-enables it.
REQ-025 Indices >= N SHALL never appear on out_idx.

Reset
REQ-026 On rst = 1 at a clock edge: pending <= 0, out_valid <= 0, out_idx <= 0, ptr <= N-1 (first round-robin search starts at 0).
REQ-027 rst SHALL take precedence over req and ack in the same cycle; req sampled during reset SHALL be discarded.
REQ-028 Reset mid-transfer SHALL drop the held index and all pending requests with no ack generated.

Verification
REQ-029 N=8, MODE=0, mask=0xFF, out_ready=1, req=0x24 for one cycle t -> out_idx=5 valid at t+2, out_idx=2 at t+3, out_valid=0 at t+4, pending=0x00 at t+4.
REQ-030 N=8, MODE=0, out_ready=0, req=0x01 at t, req=0x80 at t+3 -> out_idx=0 held from t+2 while pending=0x81; out_ready=1 at t+6 -> out_idx=7 at t+7.
REQ-031 N=8, pending=0x10, mask=0xEF -> out_valid stays 0, any_pending=1; mask=0xFF at cycle k -> out_valid=1, out_idx=4 at k+1.
REQ-032 N=8, MODE=1, req=0xFF held, out_ready=1, after reset -> out_idx sequence 0,1,2,...,7,0,1 on consecutive cycles.
REQ-033 N=8, out_idx=3 acked in the same cycle as req[3]=1 -> pending[3]=1 next cycle and index 3 is reissued later exactly once; N=5, MODE=1 -> wrap 4 -> 0, never index 5-7.
REQ-034 rst asserted while out_valid=1, out_ready=0, pending=0x81 -> next cycle out_valid=0, out_idx=0, pending=0x00, any_pending=0; MODE=1 first grant after release is the lowest eligible index.
